code_lock_ctrl: RTL and testbench
=================================

// Module: code_lock_ctrl
// PURPOSE
//  Sequencer for the keypad-to-display path. Consumes one-hot keypad events,
//  collects a 2-digit code and shows it on two 7-segment digits. '*' commits
//  the entry for comparison; '#' clears it. Drives unlock/alarm and counts failed tries.
//  Sits between the keypad scanner and the 7-segment outputs, replacing ad-hoc staging logic.
// PARAMETERS
//  CODE         8'h42  expected code, BCD {hi,lo}; each nibble 0..9
//  MAX_TRY      3      consecutive failures that trigger LOCKOUT (1..3)
//  OPEN_CYCLES  1000   cycles spent in OPEN (>=1, <2^24)
//  LOCK_CYCLES  5000   cycles spent in LOCKOUT (>=1, <2^24)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   asynchronous reset, active low
//  scan_data  in   12  one-hot key: b0..b8 = '1'..'9', b9 = '*', b10 = '0', b11 = '#'
//  valid      in   1   level; high while scan_data holds a key
//  seg_hi     out  7   tens digit, {a,b,c,d,e,f,g}, 1 = segment lit
//  seg_lo     out  7   units digit, same encoding
//  unlock     out  1   high for the whole of OPEN
//  alarm      out  1   high for the whole of LOCKOUT
//  state      out  2   00 ENTRY, 01 CHECK, 10 OPEN, 11 LOCKOUT
//  fail_cnt   out  2   consecutive failed commits
// BEHAVIOUR
//  Reset (async, rst=0): state=ENTRY, buffer empty, fail_cnt=0, timer=0.
//   Reset outputs: unlock=0, alarm=0, seg_hi=seg_lo=7'b0000000.
//   Reset mid-OPEN/LOCKOUT aborts immediately; there is no recovery of the prior state.
//  Key event:
//   - Occurs on the first cycle of valid=1; valid_q registers valid, so event = valid & ~valid_q.
//   - Holding valid gives exactly one event.
//   - If scan_data is not exactly one-hot on that cycle, the event is dropped.
//  ENTRY:
//   - Digit key: the buffer shifts, hi<=lo and lo<=digit, each with a per-digit valid flag.
//     A third digit discards the oldest.
//   - '#': clear the buffer (both flags 0).
//   - '*': go to CHECK on the same edge.
//  CHECK (exactly 1 cycle; all events ignored):
//   - Match: both flags set and {hi,lo}==CODE -> OPEN, fail_cnt<=0, timer<=OPEN_CYCLES-1.
//   - Mismatch, including fewer than 2 digits:
//     - If fail_cnt+1 == MAX_TRY -> LOCKOUT, timer<=LOCK_CYCLES-1, fail_cnt<=MAX_TRY.
//     - Otherwise -> ENTRY, fail_cnt<=fail_cnt+1.
//   - The buffer clears on every CHECK exit.
//  OPEN:
//   - unlock=1; timer decrements each cycle.
//   - At timer==0 -> ENTRY, so OPEN lasts exactly OPEN_CYCLES cycles.
//   - A '#' event -> ENTRY at once; '#' wins over timer expiry on the same cycle.
//   - Other keys are ignored.
//  LOCKOUT:
//   - alarm=1; all keys are ignored.
//   - At timer==0 -> ENTRY with fail_cnt<=0; lasts exactly LOCK_CYCLES cycles.
//  unlock, alarm and state are registered and change on the same edge as the state.
//  Display (registered; follows buffer/state one edge later):
//   - ENTRY: decoded digit, or blank 7'b0000000 if its flag is clear.
//   - CHECK: holds the previous value.
//   - OPEN: decoded CODE.
//   - LOCKOUT: 7'b0000001 ('-') on both digits.
//  Latency: key-edge sample -> buffer update at edge N -> seg outputs at edge N+1.
//  Digit-to-segment map: 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011
//                        5=1011011 6=1011111 7=1110010 8=1111111 9=1111011
//  Timer is 24-bit unsigned and never wraps; only the states above load it.
// STRUCTURE
//  Shared package (kp_pkg): key one-hot constants (KEY_0..KEY_9, KEY_STAR, KEY_HASH),
//   the SEG_* digit constants with SEG_BLANK and SEG_DASH, and the 2-bit state encoding.
//  Sub-module seg7_dec: combinational 4-bit BCD -> 7-seg decoder, shared with
//   the other display paths; codes >9 decode to SEG_BLANK.
//  One instance per digit; the FSM, timer, edge detect and buffer live in this module.
// TESTING  (CODE=8'h42, MAX_TRY=3, OPEN_CYCLES=10, LOCK_CYCLES=20)
//  1. Reset, no keys -> state=00, segs 0000000/0000000, unlock=alarm=0, fail_cnt=0.
//  2. Keys 4,2,* (valid held 3 cycles each, 2 idle between):
//     -> seg_hi=0110011, seg_lo=1101101; CHECK 1 cycle; unlock=1 for exactly 10 cycles.
//  3. Keys 1,* three times -> fail_cnt 1,2 then state=11, alarm=1 for 20 cycles,
//     keys ignored meanwhile; afterwards state=00, fail_cnt=0.
//  4. Keys 7,4,2,* -> buffer 42, unlock; then '#' at cycle 3 of OPEN -> ENTRY next edge.
//  5. Single key 4 then * -> mismatch, fail_cnt=1; key 5 then # -> both segs blank.
//  6. scan_data=12'h003 with valid -> no change; assert rst low during OPEN
//     -> unlock=0 asynchronously, state=00.

Source files
------------

// File: rtl/kp_pkg.sv
// Keypad and 7-segment constants shared by the keypad/display path.
// Key encoding is one-hot as delivered by the keypad scanner.
package kp_pkg;

  localparam logic [11:0] KEY_1    = 12'h001;
  localparam logic [11:0] KEY_2    = 12'h002;
  localparam logic [11:0] KEY_3    = 12'h004;
  localparam logic [11:0] KEY_4    = 12'h008;
  localparam logic [11:0] KEY_5    = 12'h010;
  localparam logic [11:0] KEY_6    = 12'h020;
  localparam logic [11:0] KEY_7    = 12'h040;
  localparam logic [11:0] KEY_8    = 12'h080;
  localparam logic [11:0] KEY_9    = 12'h100;
  localparam logic [11:0] KEY_STAR = 12'h200;
  localparam logic [11:0] KEY_0    = 12'h400;
  localparam logic [11:0] KEY_HASH = 12'h800;

  // Segment order {a,b,c,d,e,f,g}, 1 = lit
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110010;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'b00,
    ST_CHECK   = 2'b01,
    ST_OPEN    = 2'b10,
    ST_LOCKOUT = 2'b11
  } state_t;

  // BCD value of a one-hot digit key; b0..b8 are '1'..'9', b10 is '0'
  function automatic logic [3:0] key_digit(input logic [11:0] key);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < 9; i++)
      if (key[i]) d = 4'(i + 1);
    return d;
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD to 7-segment decoder; non-decimal codes show blank.
module seg7_dec
  import kp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/code_lock_ctrl.sv
// Two-digit code lock: keypad edge detect, digit buffer, check/open/lockout
// sequencing and the registered 7-segment display of the entry.
module code_lock_ctrl
  import kp_pkg::*;
#(
  parameter logic [7:0] CODE        = 8'h42,
  parameter int         MAX_TRY     = 3,
  parameter int         OPEN_CYCLES = 1000,
  parameter int         LOCK_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] scan_data,
  input  logic        valid,
  output logic [6:0]  seg_hi,
  output logic [6:0]  seg_lo,
  output logic        unlock,
  output logic        alarm,
  output logic [1:0]  state,
  output logic [1:0]  fail_cnt
);

  localparam logic [23:0] OPEN_LOAD = 24'(OPEN_CYCLES - 1);
  localparam logic [23:0] LOCK_LOAD = 24'(LOCK_CYCLES - 1);
  localparam logic [2:0]  TRY_LIM   = 3'(MAX_TRY);

  state_t      state_q;
  logic        valid_q;
  logic [3:0]  buf_hi, buf_lo;
  logic        hi_v, lo_v;
  logic [23:0] timer;

  logic        key_ev, is_star, is_hash, code_match;
  logic [2:0]  fail_next;
  logic [3:0]  dec_hi_in, dec_lo_in;
  logic [6:0]  dec_hi, dec_lo;

  // Single event per press, and only for a clean one-hot code
  assign key_ev     = valid & ~valid_q & $onehot(scan_data);
  assign is_star    = scan_data[9];
  assign is_hash    = scan_data[11];
  assign code_match = hi_v & lo_v & ({buf_hi, buf_lo} == CODE);
  assign fail_next  = {1'b0, fail_cnt} + 3'd1;
  assign state      = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_ENTRY;
      valid_q  <= 1'b0;
      buf_hi   <= 4'd0;
      buf_lo   <= 4'd0;
      hi_v     <= 1'b0;
      lo_v     <= 1'b0;
      timer    <= 24'd0;
      fail_cnt <= 2'd0;
      unlock   <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      valid_q <= valid;
      case (state_q)
        ST_ENTRY: begin
          if (key_ev) begin
            if (is_star) begin
              state_q <= ST_CHECK;
            end else if (is_hash) begin
              hi_v <= 1'b0;
              lo_v <= 1'b0;
            end else begin
              buf_hi <= buf_lo;
              hi_v   <= lo_v;
              buf_lo <= key_digit(scan_data);
              lo_v   <= 1'b1;
            end
          end
        end
        ST_CHECK: begin
          hi_v <= 1'b0;
          lo_v <= 1'b0;
          if (code_match) begin
            state_q  <= ST_OPEN;
            fail_cnt <= 2'd0;
            timer    <= OPEN_LOAD;
            unlock   <= 1'b1;
          end else if (fail_next == TRY_LIM) begin
            state_q  <= ST_LOCKOUT;
            fail_cnt <= TRY_LIM[1:0];
            timer    <= LOCK_LOAD;
            alarm    <= 1'b1;
          end else begin
            state_q  <= ST_ENTRY;
            fail_cnt <= fail_next[1:0];
          end
        end
        ST_OPEN: begin
          // '#' takes priority over expiry; both leave the same way
          if ((key_ev && is_hash) || timer == 24'd0) begin
            state_q <= ST_ENTRY;
            unlock  <= 1'b0;
          end else begin
            timer <= timer - 24'd1;
          end
        end
        ST_LOCKOUT: begin
          if (timer == 24'd0) begin
            state_q  <= ST_ENTRY;
            alarm    <= 1'b0;
            fail_cnt <= 2'd0;
          end else begin
            timer <= timer - 24'd1;
          end
        end
        default: state_q <= ST_ENTRY;
      endcase
    end
  end

  // One decoder per digit; OPEN shows the stored code instead of the buffer
  assign dec_hi_in = (state_q == ST_OPEN) ? CODE[7:4] : buf_hi;
  assign dec_lo_in = (state_q == ST_OPEN) ? CODE[3:0] : buf_lo;

  seg7_dec u_dec_hi (.bcd(dec_hi_in), .seg(dec_hi));
  seg7_dec u_dec_lo (.bcd(dec_lo_in), .seg(dec_lo));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_hi <= SEG_BLANK;
      seg_lo <= SEG_BLANK;
    end else begin
      case (state_q)
        ST_ENTRY: begin
          seg_hi <= hi_v ? dec_hi : SEG_BLANK;
          seg_lo <= lo_v ? dec_lo : SEG_BLANK;
        end
        ST_OPEN: begin
          seg_hi <= dec_hi;
          seg_lo <= dec_lo;
        end
        ST_LOCKOUT: begin
          seg_hi <= SEG_DASH;
          seg_lo <= SEG_DASH;
        end
        default: ; // CHECK holds the previous display
      endcase
    end
  end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Scoreboard bench for code_lock_ctrl: expectations are queued as stimulus
// is applied and popped when the corresponding output sample is taken.
module tb_code_lock_ctrl;

  localparam logic [11:0] K0 = 12'h400, K1 = 12'h001, K2 = 12'h002, K4 = 12'h008;
  localparam logic [11:0] K5 = 12'h010, K7 = 12'h040, K9 = 12'h100;
  localparam logic [11:0] KSTAR = 12'h200, KHASH = 12'h800;

  localparam logic [6:0] S0 = 7'b1111110, S2 = 7'b1101101, S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011, S9 = 7'b1111011;
  localparam logic [6:0] BL = 7'b0000000, DS = 7'b0000001;

  logic        clk, rst, valid;
  logic [11:0] scan_data;
  logic [6:0]  seg_hi, seg_lo;
  logic        unlock, alarm;
  logic [1:0]  state, fail_cnt;

  logic [19:0] obs, e;
  logic [19:0] exp_q[$];
  int          checks, errors;

  code_lock_ctrl #(
    .CODE(8'h42), .MAX_TRY(3), .OPEN_CYCLES(10), .LOCK_CYCLES(20)
  ) dut (
    .clk(clk), .rst(rst), .scan_data(scan_data), .valid(valid),
    .seg_hi(seg_hi), .seg_lo(seg_lo), .unlock(unlock), .alarm(alarm),
    .state(state), .fail_cnt(fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {state, fail_cnt, unlock, alarm, seg_hi, seg_lo};

  function automatic logic [19:0] mk(input logic [1:0] s, input logic [1:0] f,
                                     input logic u, input logic a,
                                     input logic [6:0] h, input logic [6:0] l);
    return {s, f, u, a, h, l};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Key held 3 cycles then 2 idle cycles
  task automatic press(input logic [11:0] k);
    scan_data = k;
    valid = 1'b1;
    repeat (3) tick();
    valid = 1'b0;
    scan_data = 12'h000;
    repeat (2) tick();
  endtask

  task automatic test_reset;
    repeat (2) tick();
    exp_q.push_back(mk(2'b00, 2'd0, 1'b0, 1'b0, BL, BL));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_held: got %h want %h", obs, e); end
    rst = 1'b1;
    repeat (2) tick();
    exp_q.push_back(mk(2'b00, 2'd0, 1'b0, 1'b0, BL, BL));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_idle: got %h want %h", obs, e); end
  endtask

  task automatic test_open;
    int n;
    press(K4); press(K2);
    exp_q.push_back(mk(2'b00, 2'd0, 1'b0, 1'b0, S4, S2));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL entry_42: got %h want %h", obs, e); end
    scan_data = KSTAR; valid = 1'b1;
    tick();
    valid = 1'b0; scan_data = 12'h000;
    exp_q.push_back(mk(2'b01, 2'd0, 1'b0, 1'b0, S4, S2));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL check_state: got %h want %h", obs, e); end
    n = 0;
    tick();
    while (unlock === 1'b1 && n < 100) begin
      if (n == 2) begin
        exp_q.push_back(mk(2'b10, 2'd0, 1'b1, 1'b0, S4, S2));
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL open_show: got %h want %h", obs, e); end
      end
      n++;
      tick();
    end
    checks++;
    if (n !== 10) begin errors++; $display("FAIL open_len: got %0d want 10", n); end
    tick();
    exp_q.push_back(mk(2'b00, 2'd0, 1'b0, 1'b0, BL, BL));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL open_exit: got %h want %h", obs, e); end
  endtask

  task automatic test_lockout;
    int n;
    press(K1); press(KSTAR);
    exp_q.push_back(mk(2'b00, 2'd1, 1'b0, 1'b0, BL, BL));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL fail_1: got %h want %h", obs, e); end
    press(K1); press(KSTAR);
    exp_q.push_back(mk(2'b00, 2'd2, 1'b0, 1'b0, BL, BL));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL fail_2: got %h want %h", obs, e); end
    press(K1);
    scan_data = KSTAR; valid = 1'b1;
    tick();
    valid = 1'b0; scan_data = 12'h000;
    n = 0;
    tick();
    while (alarm === 1'b1 && n < 100) begin
      if (n == 3) begin scan_data = K4; valid = 1'b1; end
      if (n == 6) begin valid = 1'b0; scan_data = 12'h000; end
      if (n == 10) begin
        exp_q.push_back(mk(2'b11, 2'd3, 1'b0, 1'b1, DS, DS));
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL lock_mid: got %h want %h", obs, e); end
      end
      n++;
      tick();
    end
    checks++;
    if (n !== 20) begin errors++; $display("FAIL lock_len: got %0d want 20", n); end
    tick();
    exp_q.push_back(mk(2'b00, 2'd0, 1'b0, 1'b0, BL, BL));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL lock_exit: got %h want %h", obs, e); end
  endtask

  task automatic test_hash_abort;
    press(K7); press(K4); press(K2);
    exp_q.push_back(mk(2'b00, 2'd0, 1'b0, 1'b0, S4, S2));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL shift_742: got %h want %h", obs, e); end
    scan_data = KSTAR; valid = 1'b1;
    tick();
    valid = 1'b0; scan_data = 12'h000;
    tick();
    exp_q.push_back(mk(2'b10, 2'd0, 1'b1, 1'b0, S4, S2));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL open_enter: got %h want %h", obs, e); end
    repeat (2) tick();
    scan_data = KHASH; valid = 1'b1;
    exp_q.push_back(mk(2'b00, 2'd0, 1'b0, 1'b0, S4, S2));
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL hash_abort: got %h want %h", obs, e); end
    valid = 1'b0; scan_data = 12'h000;
    tick();
    exp_q.push_back(mk(2'b00, 2'd0, 1'b0, 1'b0, BL, BL));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL abort_blank: got %h want %h", obs, e); end
  endtask

  task automatic test_short_and_clear;
    press(K4); press(KSTAR);
    exp_q.push_back(mk(2'b00, 2'd1, 1'b0, 1'b0, BL, BL));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL short_code: got %h want %h", obs, e); end
    press(K5);
    exp_q.push_back(mk(2'b00, 2'd1, 1'b0, 1'b0, BL, S5));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL one_digit: got %h want %h", obs, e); end
    press(KHASH);
    exp_q.push_back(mk(2'b00, 2'd1, 1'b0, 1'b0, BL, BL));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL hash_clear: got %h want %h", obs, e); end
    press(K9); press(K0);
    exp_q.push_back(mk(2'b00, 2'd1, 1'b0, 1'b0, S9, S0));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL entry_90: got %h want %h", obs, e); end
  endtask

  task automatic test_bad_key_and_async_rst;
    press(12'h003);
    exp_q.push_back(mk(2'b00, 2'd1, 1'b0, 1'b0, S9, S0));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL not_onehot: got %h want %h", obs, e); end
    press(K4); press(K2); press(KSTAR);
    exp_q.push_back(mk(2'b10, 2'd0, 1'b1, 1'b0, S4, S2));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL open_again: got %h want %h", obs, e); end
    #2 rst = 1'b0;
    exp_q.push_back(mk(2'b00, 2'd0, 1'b0, 1'b0, BL, BL));
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL async_rst: got %h want %h", obs, e); end
    #2 rst = 1'b1;
    repeat (3) tick();
    exp_q.push_back(mk(2'b00, 2'd0, 1'b0, 1'b0, BL, BL));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL post_rst: got %h want %h", obs, e); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    valid = 1'b0;
    scan_data = 12'h000;
    test_reset();
    test_open();
    test_lockout();
    test_hash_abort();
    test_short_and_clear();
    test_bad_key_and_async_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
